// File: rtl/uart_tx_buffered_if.sv
// Bus-side handshake for uart_tx_buffered: the byte to send, its write
// strobe and the buffer-ready flag returned by the transmitter.
interface uart_tx_buffered_if;
  logic [7:0] TxD_data;
  logic       wr_tx;
  logic       TBR;

  modport master (output TxD_data, output wr_tx, input TBR);
  modport slave  (input TxD_data, input wr_tx, output TBR);
endinterface

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter with a one-entry holding register.
// Bit timing comes from the shared Baud tick (OVERSAMPLE ticks per bit).
// A byte waiting in the holding register is loaded at the end of the stop
// bit so consecutive frames leave no idle gap on the line.
// Optional feature: define UART_TX_PARITY_EN to append an even parity bit
// between the data bits and the stop bit (8E1 framing).
module uart_tx_buffered #(
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Baud,
  uart_tx_buffered_if.slave     bus,
  output logic                  TxD,
  output logic                  tx_busy
);

  localparam int BW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t          state_q;
  logic            txd_q;
  logic [7:0]      hold_buf_q;
  logic            hold_full_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic [BW-1:0]   baud_cnt_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  // Last Baud tick of the current bit period; the transition consumes it.
  logic bit_end_s;
  assign bit_end_s = Baud && (baud_cnt_q == BAUD_LAST);

  assign bus.TBR = ~hold_full_q;
  assign TxD     = txd_q;
  assign tx_busy = (state_q != S_IDLE);

  // Holding register, bit timing and frame sequencing with registered TxD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      txd_q       <= 1'b1;
      hold_buf_q  <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      baud_cnt_q  <= BAUD_ZERO;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // Writes land only in an empty holding register; a load below needs
      // it full, so the two never act in the same cycle.
      if (bus.wr_tx && !hold_full_q) begin
        hold_buf_q  <= bus.TxD_data;
        hold_full_q <= 1'b1;
      end

      if ((state_q != S_IDLE) && Baud) begin
        baud_cnt_q <= bit_end_s ? BAUD_ZERO : (baud_cnt_q + BAUD_ONE);
      end

      case (state_q)
        S_IDLE: begin
          txd_q      <= 1'b1;
          baud_cnt_q <= BAUD_ZERO;
          if (hold_full_q) begin
            shift_q     <= hold_buf_q;
`ifdef UART_TX_PARITY_EN
            parity_q    <= ^hold_buf_q;
`endif
            hold_full_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            state_q     <= S_START;
            txd_q       <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end_s) begin
            state_q <= S_DATA;
            txd_q   <= shift_q[0];
          end
        end

        S_DATA: begin
          if (bit_end_s) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= parity_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              txd_q <= shift_q[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end_s) begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end_s) begin
            if (hold_full_q) begin
              // Next byte already waiting: start bit follows immediately.
              shift_q     <= hold_buf_q;
`ifdef UART_TX_PARITY_EN
              parity_q    <= ^hold_buf_q;
`endif
              hold_full_q <= 1'b0;
              bit_cnt_q   <= 3'd0;
              state_q     <= S_START;
              txd_q       <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              txd_q   <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: table-driven single frames,
// hand-written back-to-back / dropped-write / reset sequences, then random
// traffic compared cycle by cycle against a frame-position reference model.
module tb_uart_tx_buffered;

  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FT  = NB * OS;
  localparam int MAX = 512;

  logic clk = 1'b0;
  logic rst;
  logic baud;
  logic txd;
  logic tx_busy;

  uart_tx_buffered_if bus_if ();

  uart_tx_buffered #(.OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .rst     (rst),
    .Baud    (baud),
    .bus     (bus_if.slave),
    .TxD     (txd),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- directed capture machinery ----------------
  logic       line_a [MAX];
  logic       tbr_a  [MAX];
  logic       busy_a [MAX];
  logic       ev_en  [MAX];
  logic [7:0] ev_data[MAX];
  int         fcnt;
  int         fst [8];
  logic [10:0] ffr [8];

  task automatic clear_sched();
    for (int i = 0; i < MAX; i++) begin
      ev_en[i]   = 1'b0;
      ev_data[i] = 8'h00;
    end
  endtask

  // Record outputs at each falling edge, then drive that cycle's write.
  task automatic run_seq(input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      line_a[c] = txd;
      tbr_a[c]  = bus_if.TBR;
      busy_a[c] = tx_busy;
      bus_if.wr_tx    = ev_en[c];
      bus_if.TxD_data = ev_data[c];
      baud = 1'b1;
    end
    @(negedge clk);
    bus_if.wr_tx = 1'b0;
  endtask

  // Find frames on the recorded line; sample each bit mid-period.
  task automatic decode(input int len);
    int p;
    fcnt = 0;
    p = 0;
    while (p + FT <= len && fcnt < 8) begin
      if (line_a[p] == 1'b0) begin
        fst[fcnt] = p;
        ffr[fcnt] = 11'd0;
        for (int k = 0; k < NB; k++) ffr[fcnt][k] = line_a[p + OS/2 + OS*k];
        fcnt++;
        p += FT;
      end else begin
        p++;
      end
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [9:0] f10, input logic par);
`ifdef UART_TX_PARITY_EN
    return {f10[9], par, f10[8:0]};
`else
    return {1'b0, f10};
`endif
  endfunction

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;   // {stop, data MSB..LSB, start}
    logic       par;
  } vec_t;
  vec_t tbl[8];

  // ---------------- reference model ----------------
  bit         m_in_frame;
  int         m_left;
  logic [7:0] m_cur;
  bit         m_hold;
  logic [7:0] m_hold_d;

  task automatic model_reset();
    m_in_frame = 0; m_left = 0; m_cur = 8'h00; m_hold = 0; m_hold_d = 8'h00;
  endtask

  // One clock edge with the given inputs.
  task automatic model_step(input bit b, input bit wr, input logic [7:0] d);
    bit h_old;
    h_old = m_hold;
    if (m_in_frame) begin
      if (b) begin
        m_left--;
        if (m_left == 0) begin
          if (h_old) begin
            m_cur = m_hold_d; m_left = FT; m_hold = 0;
          end else begin
            m_in_frame = 0;
          end
        end
      end
    end else if (h_old) begin
      m_in_frame = 1; m_cur = m_hold_d; m_left = FT; m_hold = 0;
    end
    if (wr && !h_old) begin
      m_hold = 1; m_hold_d = d;
    end
  endtask

  function automatic logic model_txd();
    int idx;
    if (!m_in_frame) return 1'b1;
    idx = (FT - m_left) / OS;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  initial begin
    int lows;
    int busy_n;
    rst = 1'b1;
    baud = 1'b0;
    bus_if.wr_tx = 1'b0;
    bus_if.TxD_data = 8'h00;
    #1;
    chk("reset_txd", txd, 1'b1);
    chk("reset_tbr", bus_if.TBR, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{8'h55, 10'b1_01010101_0, 1'b0};
    tbl[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
    tbl[2] = '{8'h03, 10'b1_00000011_0, 1'b0};
    tbl[3] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    tbl[4] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    tbl[5] = '{8'h00, 10'b1_00000000_0, 1'b0};
    tbl[6] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    tbl[7] = '{8'h80, 10'b1_10000000_0, 1'b1};

    // Single frames from idle, Baud every cycle.
    for (int v = 0; v < 8; v++) begin
      clear_sched();
      ev_en[0] = 1'b1; ev_data[0] = tbl[v].d;
      run_seq(2 + FT + 4);
      chk("tbr_low_after_wr", tbr_a[1], 1'b0);
      chk("tbr_back_n2", tbr_a[2], 1'b1);
      chk("txd_high_n1", line_a[1], 1'b1);
      chk("txd_fall_n2", line_a[2], 1'b0);
      decode(2 + FT + 4);
      chk("single_frame_count", fcnt, 1);
      chk("single_frame_start", fst[0], 2);
      chk("single_frame_bits", ffr[0], exp_frame(tbl[v].frame, tbl[v].par));
      chk("busy_last_tick", busy_a[2 + FT - 1], 1'b1);
      chk("idle_after_frame", busy_a[2 + FT], 1'b0);
      chk("line_idle_after", line_a[2 + FT], 1'b1);
    end

    // Back-to-back: second write as soon as TBR returns.
    clear_sched();
    ev_en[0] = 1'b1; ev_data[0] = 8'hA5;
    ev_en[2] = 1'b1; ev_data[2] = 8'h3C;
    run_seq(2 + 2*FT + 4);
    decode(2 + 2*FT + 4);
    chk("b2b_frame_count", fcnt, 2);
    chk("b2b_second_start", fst[1], 2 + FT);
    chk("b2b_frame0", ffr[0], exp_frame(10'b1_10100101_0, 1'b0));
    chk("b2b_frame1", ffr[1], exp_frame(10'b1_00111100_0, 1'b0));
    chk("b2b_stop_before", line_a[2 + FT - 1], 1'b1);
    busy_n = 0;
    for (int i = 0; i < 2 + 2*FT + 4; i++) if (busy_a[i]) busy_n++;
    chk("b2b_busy_ticks", busy_n, 2*FT);

    // Dropped write while the holding register is full.
    clear_sched();
    ev_en[0] = 1'b1; ev_data[0] = 8'h11;
    ev_en[1] = 1'b1; ev_data[1] = 8'h22;
    ev_en[2] = 1'b1; ev_data[2] = 8'h33;
    run_seq(2 + 2*FT + 20);
    decode(2 + 2*FT + 20);
    chk("drop_frame_count", fcnt, 2);
    chk("drop_frame0", ffr[0], exp_frame(10'b1_00010001_0, 1'b0));
    chk("drop_frame1", ffr[1], exp_frame(10'b1_00110011_0, 1'b1 ^ 1'b1));

    // Reset mid-frame with a byte waiting in the holding register.
    clear_sched();
    ev_en[0] = 1'b1; ev_data[0] = 8'h00;
    ev_en[2] = 1'b1; ev_data[2] = 8'hFF;
    run_seq(40);
    #2 rst = 1'b1;
    #1;
    chk("midreset_txd", txd, 1'b1);
    chk("midreset_tbr", bus_if.TBR, 1'b1);
    chk("midreset_busy", tx_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_sched();
    run_seq(2*OS + 8);
    lows = 0;
    for (int i = 0; i < 2*OS + 8; i++) if (!line_a[i] || busy_a[i]) lows++;
    chk("post_reset_quiet", lows, 0);

    // Random traffic against the reference model.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 12000; c++) begin
      bit b;
      bit w;
      logic [7:0] d;
      if (c != 0) @(negedge clk);
      chk("rand_txd", txd, model_txd());
      chk("rand_tbr", bus_if.TBR, !m_hold);
      chk("rand_busy", tx_busy, m_in_frame);
      b = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 9) == 0);
      d = 8'($urandom);
      baud = b;
      bus_if.wr_tx = w;
      bus_if.TxD_data = d;
      model_step(b, w, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
